vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Shares the single VGA adapter pixel-write port between up to NUM_REQ drawing engines: the note plotter, the hit-flash/score drawer and the background restorer. It grants the port round-robin, one burst at a time, and muxes the granted engine's x/y/colour/write into a registered pixel stream. It sits between the engines and the vga_adapter, and replaces the hard-wired plotter-to-VGA connection with plot tied high.

## Interface
- NUM_REQ, 3: number of requesters. Legal range 2..4.
- MAX_HOLD, 1024: maximum cycles a grant may be held before forced release.
- HOLD_W, 11: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester port request; level, held for the whole burst
- wr  in  NUM_REQ  per-requester pixel valid; honoured only while that requester holds gnt
- last  in  NUM_REQ  marks the final pixel of a burst; qualified by wr
- x_in  in  9*NUM_REQ  packed x; requester i uses bits [9i+8:9i]
- y_in  in  8*NUM_REQ  packed y; requester i uses bits [8i+7:8i]
- colour_in  in  9*NUM_REQ  packed 9-bit colour; requester i uses bits [9i+8:9i]
- gnt  out  NUM_REQ  one-hot grant; all zero when no requester is granted
- x_out  out  9  x to the VGA adapter
- y_out  out  8  y to the VGA adapter
- colour_out  out  9  colour to the VGA adapter
- plot_out  out  1  pixel write strobe to the VGA adapter
- busy  out  1  high whenever the FSM is not in IDLE
- timeout  out  1  one-cycle pulse when a grant is force-released

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE:** if any req bit is high, pick the first set bit searching from pointer ptr upward, wrapping modulo NUM_REQ. Set gnt to that bit, clear hold_cnt, go to GRANT.
- **GRANT (owner k):** while wr[k]=1, register x/y/colour of slot k and pulse plot_out. wr of non-owners is ignored and their pixels are dropped.
  - hold_cnt increments every cycle, saturating at MAX_HOLD.
  - The burst ends in the cycle with wr[k]&last[k], or when req[k]=0, or when hold_cnt = MAX_HOLD−1. Go to RELEASE.
  - On the timeout exit, pulse timeout. The pixel in that cycle, if wr[k]=1, is still written.
- **RELEASE:** gnt = 0, ptr ← (k+1) mod NUM_REQ. Go to IDLE. This gives a one-cycle bubble that guarantees the next grantee sees a gnt rising edge.
- Fairness: no requester is granted twice while another requester continuously holds req.
- Simultaneous events:
  - If last and req drop happen in the same cycle, there is a single exit with no timeout pulse.
  - If last coincides with hold expiry, last wins and there is no timeout pulse.
- If req[k] is asserted while k is in RELEASE, k competes normally in the next IDLE. ptr already excludes it from first priority.
- wr with no grant is dropped silently.
- Reset (asynchronous, any state): FSM → IDLE, ptr = 0, hold_cnt = 0. gnt, x_out, y_out, colour_out, plot_out, busy and timeout all go to 0.
  - A burst interrupted by reset is abandoned. The requester must re-request.

## Timing
- Request to grant: req rising in cycle t is seen in IDLE at edge t+1, and gnt is high after that edge. Minimum 1 cycle.
- Pixel latency: wr/x/y/colour accepted at edge n appear on x_out/y_out/colour_out/plot_out for the cycle after edge n (1-cycle register latency, no bubbles within a burst).
- Burst end: gnt drops after the edge that enters RELEASE. The earliest next grant is 2 edges after the burst-ending edge.
- plot_out is high only for cycles following accepted pixels. Between pixels x_out, y_out and colour_out hold their last values.
- Maximum pixels per grant: MAX_HOLD.
- Worst-case wait for a requester: (NUM_REQ−1)·(MAX_HOLD+2) cycles.

## Test plan
- **Reset mid-burst:** requester 0 streams 5 pixels; assert resetn=0 after 3 → gnt=0, plot_out=0 and all outputs 0 asynchronously. After release, req[0] is re-granted 1 cycle after sampling.
- **Single burst:** req[1] with pixels (10,20,0x1FF), (11,20,0x1FF), the second with last → gnt=3'b010 one cycle after req. plot_out pulses on 2 consecutive cycles with matching values. gnt clears, busy returns to 0 after RELEASE.
- **Round-robin:** req = 3'b111 held, each burst 1 pixel with last → grant order 0,1,2,0. Exactly one idle cycle between grants.
- **Timeout:** MAX_HOLD=8, req[2] held with wr=1 and never last → exactly 8 plot_out pulses. timeout pulses once, gnt[2] drops, then req[0] (pending) is granted.
- **Non-owner isolation:** requester 0 owns the port while requester 1 drives wr=1 with x=99 → x_out never shows 99, and requester 1 is granted only after requester 0's burst ends.
- **Simultaneous last and expiry:** MAX_HOLD=4, last on the 4th pixel → no timeout pulse, 4 pixels written.

Source files
------------

// File: rtl/vga_plot_if.sv
// Bundle between the drawing engines (master) and the pixel-port arbiter (slave):
// per-requester request/pixel lanes in, one registered VGA pixel stream out.
interface vga_plot_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   wr;
  logic [NUM_REQ-1:0]   last;
  logic [9*NUM_REQ-1:0] x_in;
  logic [8*NUM_REQ-1:0] y_in;
  logic [9*NUM_REQ-1:0] colour_in;
  logic [NUM_REQ-1:0]   gnt;
  logic [8:0]           x_out;
  logic [7:0]           y_out;
  logic [8:0]           colour_out;
  logic                 plot_out;
  logic                 busy;
  logic                 timeout;

  modport master (
    output req, wr, last, x_in, y_in, colour_in,
    input  gnt, x_out, y_out, colour_out, plot_out, busy, timeout
  );

  modport slave (
    input  req, wr, last, x_in, y_in, colour_in,
    output gnt, x_out, y_out, colour_out, plot_out, busy, timeout
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-granular arbiter for the single VGA adapter pixel port.
// The owner's pixels are registered onto x/y/colour/plot; everyone else is dropped.
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 1024,
  parameter int HOLD_W   = 11
) (
  input  logic        clk,
  input  logic        resetn,
  vga_plot_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        own_q, own_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [8:0]        colour_q, colour_d;
  logic              plot_q, plot_d;
  logic              timeout_q, timeout_d;

  // Lanes padded to four slots so a 2-bit owner/pointer indexes them for any NUM_REQ.
  logic [3:0] req_w, wr_w, last_w;
  logic [8:0] slot_x [4];
  logic [7:0] slot_y [4];
  logic [8:0] slot_c [4];

  logic       found;
  logic [1:0] pick;
  logic       own_req, own_wr, own_last, end_last, expire;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    logic [2:0] s;
    s = {1'b0, base} + 3'(off);
    if (s >= 3'(NUM_REQ)) s = s - 3'(NUM_REQ);
    return s[1:0];
  endfunction

  always_comb begin
    req_w  = '0;
    wr_w   = '0;
    last_w = '0;
    req_w[NUM_REQ-1:0]  = bus.req;
    wr_w[NUM_REQ-1:0]   = bus.wr;
    last_w[NUM_REQ-1:0] = bus.last;
    for (int i = 0; i < 4; i++) begin
      slot_x[i] = '0;
      slot_y[i] = '0;
      slot_c[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_x[i] = bus.x_in[9*i +: 9];
      slot_y[i] = bus.y_in[8*i +: 8];
      slot_c[i] = bus.colour_in[9*i +: 9];
    end
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!found && req_w[wrap_idx(ptr_q, o)]) begin
        found = 1'b1;
        pick  = wrap_idx(ptr_q, o);
      end
    end
  end

  assign own_req  = req_w[own_q];
  assign own_wr   = wr_w[own_q];
  assign own_last = last_w[own_q];
  assign end_last = own_wr & own_last;
  assign expire   = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    hold_d    = hold_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = pick;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (own_wr) begin
          x_d      = slot_x[own_q];
          y_d      = slot_y[own_q];
          colour_d = slot_c[own_q];
          plot_d   = 1'b1;
        end
        if (hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + HOLD_W'(1);
        // A real last or a dropped request takes precedence over the forced release.
        if (end_last || !own_req || expire) begin
          state_d   = RELEASE;
          timeout_d = expire & own_req & ~end_last;
        end
      end
      RELEASE: begin
        ptr_d   = wrap_idx(own_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      hold_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      hold_q    <= hold_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt        = (state_q == GRANT) ? NUM_REQ'(4'b0001 << own_q) : '0;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = colour_q;
  assign bus.plot_out   = plot_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: two instances (hold limits 8 and 4) share one stimulus
// stream and are compared every cycle against a burst-level reference model.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req, wr, last;
  logic [26:0] xs;
  logic [23:0] ys;
  logic [26:0] cs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_plot_if #(.NUM_REQ(3)) bus_a ();
  vga_plot_if #(.NUM_REQ(3)) bus_b ();

  assign bus_a.req = req;  assign bus_a.wr = wr;  assign bus_a.last = last;
  assign bus_a.x_in = xs;  assign bus_a.y_in = ys; assign bus_a.colour_in = cs;
  assign bus_b.req = req;  assign bus_b.wr = wr;  assign bus_b.last = last;
  assign bus_b.x_in = xs;  assign bus_b.y_in = ys; assign bus_b.colour_in = cs;

  vga_plot_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .HOLD_W(4)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));
  vga_plot_arbiter #(.NUM_REQ(3), .MAX_HOLD(4), .HOLD_W(3)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  // Reference model: owner (-1 = none), bubble cycles left, cycles held, pointer.
  int         m_own [2];
  int         m_bub [2];
  int         m_cnt [2];
  int         m_ptr [2];
  int         mh    [2] = '{8, 4};
  logic [2:0] e_gnt [2];
  logic       e_busy[2], e_plot[2], e_to[2];
  logic [8:0] e_x   [2];
  logic [7:0] e_y   [2];
  logic [8:0] e_c   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = -1; m_bub[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
      e_gnt[i] = '0; e_busy[i] = 0; e_plot[i] = 0; e_to[i] = 0;
      e_x[i] = '0; e_y[i] = '0; e_c[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int  k, j;
    bit  done;
    e_plot[i] = 0;
    e_to[i]   = 0;
    if (m_own[i] >= 0) begin
      k = m_own[i];
      m_cnt[i]++;
      if (wr[k]) begin
        e_x[i] = xs[9*k +: 9]; e_y[i] = ys[8*k +: 8]; e_c[i] = cs[9*k +: 9];
        e_plot[i] = 1;
      end
      if ((wr[k] && last[k]) || !req[k] || m_cnt[i] == mh[i]) begin
        e_to[i]  = !(wr[k] && last[k]) && req[k];
        m_ptr[i] = (k + 1) % 3;
        m_own[i] = -1;
        m_bub[i] = 1;
      end
    end else if (m_bub[i] > 0) begin
      m_bub[i]--;
    end else begin
      done = 0;
      for (int o = 0; o < 3; o++) begin
        j = (m_ptr[i] + o) % 3;
        if (!done && req[j]) begin
          m_own[i] = j; m_cnt[i] = 0; done = 1;
        end
      end
    end
    e_gnt[i]  = (m_own[i] >= 0) ? 3'(1 << m_own[i]) : 3'b000;
    e_busy[i] = (m_own[i] >= 0) || (m_bub[i] > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check("model_a", {bus_a.gnt, bus_a.busy, bus_a.plot_out, bus_a.timeout,
                      bus_a.x_out, bus_a.y_out, bus_a.colour_out},
                     {e_gnt[0], e_busy[0], e_plot[0], e_to[0], e_x[0], e_y[0], e_c[0]});
    check("model_b", {bus_b.gnt, bus_b.busy, bus_b.plot_out, bus_b.timeout,
                      bus_b.x_out, bus_b.y_out, bus_b.colour_out},
                     {e_gnt[1], e_busy[1], e_plot[1], e_to[1], e_x[1], e_y[1], e_c[1]});
  endtask

  typedef struct {
    logic [2:0]  req, wr, last;
    logic [26:0] xs;
    logic [2:0]  e_gnt;
    logic        e_plot, e_busy;
    logic [8:0]  e_x;
    logic [7:0]  e_y;
    logic [8:0]  e_c;
  } vec_t;

  localparam logic [26:0] XR  = {9'd102, 9'd101, 9'd100};
  localparam logic [26:0] X10 = {9'd0, 9'd10, 9'd0};
  localparam logic [26:0] X11 = {9'd0, 9'd11, 9'd0};

  vec_t tbl [16];

  initial begin
    int n_plot, n_to, waited;
    bit got;

    tbl[0]  = '{3'b111, 3'b111, 3'b111, XR,  3'b001, 1'b0, 1'b1, 9'd0,   8'd0,  9'h000};
    tbl[1]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b1, 1'b1, 9'd100, 8'd10, 9'h055};
    tbl[2]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b0, 1'b0, 9'd100, 8'd10, 9'h055};
    tbl[3]  = '{3'b111, 3'b111, 3'b111, XR,  3'b010, 1'b0, 1'b1, 9'd100, 8'd10, 9'h055};
    tbl[4]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b1, 1'b1, 9'd101, 8'd20, 9'h1FF};
    tbl[5]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b0, 1'b0, 9'd101, 8'd20, 9'h1FF};
    tbl[6]  = '{3'b111, 3'b111, 3'b111, XR,  3'b100, 1'b0, 1'b1, 9'd101, 8'd20, 9'h1FF};
    tbl[7]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b1, 1'b1, 9'd102, 8'd30, 9'h0AA};
    tbl[8]  = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b0, 1'b0, 9'd102, 8'd30, 9'h0AA};
    tbl[9]  = '{3'b111, 3'b111, 3'b111, XR,  3'b001, 1'b0, 1'b1, 9'd102, 8'd30, 9'h0AA};
    tbl[10] = '{3'b111, 3'b111, 3'b111, XR,  3'b000, 1'b1, 1'b1, 9'd100, 8'd10, 9'h055};
    tbl[11] = '{3'b000, 3'b000, 3'b000, XR,  3'b000, 1'b0, 1'b0, 9'd100, 8'd10, 9'h055};
    tbl[12] = '{3'b010, 3'b000, 3'b000, X10, 3'b010, 1'b0, 1'b1, 9'd100, 8'd10, 9'h055};
    tbl[13] = '{3'b010, 3'b010, 3'b000, X10, 3'b010, 1'b1, 1'b1, 9'd10,  8'd20, 9'h1FF};
    tbl[14] = '{3'b010, 3'b010, 3'b010, X11, 3'b000, 1'b1, 1'b1, 9'd11,  8'd20, 9'h1FF};
    tbl[15] = '{3'b000, 3'b000, 3'b000, X11, 3'b000, 1'b0, 1'b0, 9'd11,  8'd20, 9'h1FF};

    req = '0; wr = '0; last = '0; xs = '0;
    ys = {8'd30, 8'd20, 8'd10};
    cs = {9'h0AA, 9'h1FF, 9'h055};
    resetn = 1'b0;
    model_reset();
    tick(); tick();
    check("reset_state_a", {bus_a.gnt, bus_a.busy, bus_a.plot_out, bus_a.timeout,
                            bus_a.x_out, bus_a.y_out, bus_a.colour_out}, 32'd0);
    resetn = 1'b1;
    tick();

    // Round-robin order 0,1,2,0 then a two-pixel burst from requester 1.
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; wr = tbl[i].wr; last = tbl[i].last; xs = tbl[i].xs;
      tick();
      check($sformatf("vec%0d", i),
            {bus_a.gnt, bus_a.plot_out, bus_a.busy, bus_a.x_out, bus_a.y_out, bus_a.colour_out},
            {tbl[i].e_gnt, tbl[i].e_plot, tbl[i].e_busy, tbl[i].e_x, tbl[i].e_y, tbl[i].e_c});
    end

    // Forced release: requester 2 streams without last, requester 0 waits.
    req = 3'b101; wr = 3'b100; last = '0; xs = {9'd77, 9'd0, 9'd0};
    n_plot = 0; n_to = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_plot += int'(bus_a.plot_out);
      n_to   += int'(bus_a.timeout);
    end
    check("timeout_pixels", n_plot, 8);
    check("timeout_pulses", n_to, 1);
    check("timeout_next_gnt", bus_a.gnt, 3'b001);
    req = '0; wr = '0;
    repeat (3) tick();

    // Non-owner pixels must never reach the port.
    req = 3'b001;
    tick();
    req = 3'b011; wr = 3'b011; xs = {9'd0, 9'd99, 9'd5};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("iso_gnt", bus_a.gnt, 3'b001);
      check("iso_x_not_99", 32'(bus_a.x_out == 9'd99), 32'd0);
    end
    last = 3'b001;
    tick();
    check("iso_x_not_99_last", 32'(bus_a.x_out == 9'd99), 32'd0);
    req = 3'b010; last = '0;
    got = 0; waited = 0;
    for (int i = 0; i < 6; i++) begin
      if (!got) begin
        tick();
        waited++;
        if (bus_a.gnt == 3'b010) got = 1;
      end
    end
    check("iso_next_grant_seen", 32'(got), 32'd1);
    check("iso_next_grant_delay", waited, 2);
    req = '0; wr = '0;
    repeat (4) tick();

    // Last on the pixel that also exhausts the 4-cycle hold of dut_b.
    req = 3'b001;
    tick();
    n_plot = 0; n_to = 0;
    for (int p = 0; p < 4; p++) begin
      wr = 3'b001; last = (p == 3) ? 3'b001 : 3'b000; xs = {18'd0, 9'(200 + p)};
      tick();
      n_plot += int'(bus_b.plot_out);
      n_to   += int'(bus_b.timeout);
    end
    req = '0; wr = '0; last = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_plot += int'(bus_b.plot_out);
      n_to   += int'(bus_b.timeout);
    end
    check("simul_pixels", n_plot, 4);
    check("simul_no_timeout", n_to, 0);
    check("simul_last_x", bus_b.x_out, 9'd203);

    // Reset in the middle of a burst.
    req = 3'b001; wr = 3'b001; xs = {18'd0, 9'd42};
    repeat (4) tick();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset_async_a", {bus_a.gnt, bus_a.busy, bus_a.plot_out, bus_a.timeout,
                            bus_a.x_out, bus_a.y_out, bus_a.colour_out}, 32'd0);
    check("reset_async_b", {bus_b.gnt, bus_b.busy, bus_b.plot_out, bus_b.timeout,
                            bus_b.x_out, bus_b.y_out, bus_b.colour_out}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("regrant_after_reset", bus_a.gnt, 3'b001);
    req = '0; wr = '0;
    repeat (3) tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      wr   = 3'($urandom);
      last = 3'($urandom & $urandom);
      xs   = 27'($urandom);
      ys   = 24'($urandom);
      cs   = 27'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
